hradd_online: RTL and testbench

Parametrised radix-2^LOG2R online (MSD-first) signed-digit adder: the high-radix successor to the radix-2 online adder. Consumes one digit of each operand per accepted cycle over an N-digit frame and emits the N+1-digit sum MSD-first with online delay 1, framed by first/last markers. It is the adder primitive for the high-radix MSDF datapath, feeding multipliers and accumulators digit-serially.

---
 rtl/hradd_pkg.sv | 20 ++
 rtl/hradd_digit_slice.sv | 37 +++
 rtl/hradd_online.sv | 106 ++++++++++
 tb/tb_hradd_online.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hradd_pkg.sv
// Shared definitions for the high-radix online adder: FSM state encoding,
// digit-width and transfer-threshold helpers.
package hradd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic int dw_of(input int log2r);
    return log2r + 1;
  endfunction

  // Transfer fires when |x+y| reaches r-1, keeping the interim digit within r-2.
  function automatic int t_thresh(input int log2r);
    return (1 << log2r) - 1;
  endfunction

endpackage

// File: rtl/hradd_digit_slice.sv
// Combinational digit slice: w = x + y, transfer t in {-1,0,+1}, interim u = w - r*t.
module hradd_digit_slice
  import hradd_pkg::*;
#(
  parameter int LOG2R = 2,
  parameter int DW    = dw_of(LOG2R)
) (
  input  logic [DW-1:0] x,
  input  logic [DW-1:0] y,
  output logic [1:0]    t,
  output logic [DW-1:0] u
);

  localparam logic signed [DW:0] THR_POS = (DW+1)'(t_thresh(LOG2R));
  localparam logic signed [DW:0] THR_NEG = -THR_POS;
  localparam logic signed [DW:0] RADIX   = (DW+1)'(1 << LOG2R);

  logic signed [DW:0] w;
  logic signed [DW:0] u_full;

  assign w = $signed({x[DW-1], x}) + $signed({y[DW-1], y});

  always_comb begin
    t      = 2'b00;
    u_full = w;
    if (w >= THR_POS) begin
      t      = 2'b01;
      u_full = w - RADIX;
    end else if (w <= THR_NEG) begin
      t      = 2'b11;
      u_full = w + RADIX;
    end
  end

  assign u = u_full[DW-1:0];

endmodule

// File: rtl/hradd_online.sv
// Radix-2^LOG2R online (MSD-first) signed-digit adder, online delay 1.
// Optional illegal-digit (-r) detection enabled by HRADD_DIGIT_CHECK_EN.
module hradd_online
  import hradd_pkg::*;
#(
  parameter int LOG2R = 2,
  parameter int N     = 8,
  parameter int DW    = dw_of(LOG2R)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          in_first,
  output logic          in_ready,
  input  logic [DW-1:0] x_j,
  input  logic [DW-1:0] y_j,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic [DW-1:0] out_digit,
  output logic          err
);

  localparam logic [1:0] S_IDLE  = 2'(IDLE);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_FLUSH = 2'(FLUSH);
  localparam int         CW      = $clog2(N + 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] u_reg;
  logic [1:0]    t_new;
  logic [DW-1:0] u_new;
  logic [DW-1:0] t_ext;
  logic          accept;

  hradd_digit_slice #(.LOG2R(LOG2R), .DW(DW)) u_slice (
    .x (x_j),
    .y (y_j),
    .t (t_new),
    .u (u_new)
  );

  assign in_ready = (state != S_FLUSH);
  assign accept   = in_valid & in_ready;
  assign t_ext    = {{(DW-2){t_new[1]}}, t_new};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      u_reg     <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_digit <= '0;
    end else begin
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          // pairs without in_first are dropped here so a stray tail never starts a frame
          if (accept && in_first) begin
            out_valid <= 1'b1;
            out_first <= 1'b1;
            out_digit <= t_ext;
            u_reg     <= u_new;
            cnt       <= CW'(1);
            state     <= (N == 1) ? S_FLUSH : S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            out_valid <= 1'b1;
            out_digit <= u_reg + t_ext;
            u_reg     <= u_new;
            cnt       <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          out_valid <= 1'b1;
          out_last  <= 1'b1;
          out_digit <= u_reg;
          u_reg     <= '0;
          cnt       <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HRADD_DIGIT_CHECK_EN
  localparam logic [DW-1:0] NEG_R = {1'b1, {LOG2R{1'b0}}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (accept && ((x_j == NEG_R) || (y_j == NEG_R))) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hradd_online.sv
// Directed bench for hradd_online at LOG2R=2 (radix 4), N=4.
module tb_hradd_online;

  localparam int LOG2R = 2;
  localparam int N     = 4;
  localparam int DW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_first = 1'b0;
  logic          in_ready;
  logic [DW-1:0] x_j = '0;
  logic [DW-1:0] y_j = '0;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic [DW-1:0] out_digit;
  logic          err;

  int checks = 0;
  int errors = 0;

  typedef struct {int d; bit f; bit l;} od_t;
  od_t q[$];
  bit  cnt_rdy = 1'b0;
  int  rdy_low = 0;

  hradd_online #(.LOG2R(LOG2R), .N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_ready  (in_ready),
    .x_j       (x_j),
    .y_j       (y_j),
    .out_valid (out_valid),
    .out_first (out_first),
    .out_last  (out_last),
    .out_digit (out_digit),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid) q.push_back('{int'($signed(out_digit)), out_first, out_last});
    if (cnt_rdy && !in_ready) rdy_low++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic f);
    int n;
    n        = 0;
    in_valid = 1'b1;
    x_j      = x;
    y_j      = y;
    in_first = f;
    while (!in_ready && n < 8) begin
      tick(1);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
    tick(1);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] xs[4], input logic [DW-1:0] ys[4], input int gap);
    for (int i = 0; i < N; i++) begin
      send(xs[i], ys[i], i == 0);
      if (gap > 0 && i < N - 1) tick(gap);
    end
  endtask

  task automatic check_frame(input string tag, input int base, input int exp[5]);
    for (int k = 0; k < 5; k++) begin
      if (base + k < q.size()) begin
        chk($sformatf("%s_d%0d", tag, k), q[base+k].d, exp[k]);
        chk($sformatf("%s_f%0d", tag, k), int'(q[base+k].f), (k == 0) ? 1 : 0);
        chk($sformatf("%s_l%0d", tag, k), int'(q[base+k].l), (k == 4) ? 1 : 0);
      end else begin
        chk($sformatf("%s_missing%0d", tag, k), q.size(), base + k + 1);
      end
    end
  endtask

  logic [DW-1:0] x_p3[4] = '{3'b011, 3'b011, 3'b011, 3'b011};
  logic [DW-1:0] x_m3[4] = '{3'b101, 3'b101, 3'b101, 3'b101};
  logic [DW-1:0] x_2[4]  = '{3'b010, 3'b000, 3'b000, 3'b000};
  logic [DW-1:0] y_1[4]  = '{3'b001, 3'b000, 3'b000, 3'b000};
  logic [DW-1:0] x_bad[4] = '{3'b100, 3'b000, 3'b000, 3'b000};
  logic [DW-1:0] zero4[4] = '{3'b000, 3'b000, 3'b000, 3'b000};
  int e_p3[5] = '{1, 3, 3, 3, 2};
  int e_21[5] = '{1, -1, 0, 0, 0};
  int e_m3[5] = '{-1, -3, -3, -3, -2};
  int nlast;

  initial begin
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_first", int'(out_first), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_digit", int'(out_digit), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ready", int'(in_ready), 1);
    tick(2);
    reset = 1'b0;
    tick(1);

    q.delete();
    send_frame(x_p3, x_p3, 0);
    tick(4);
    chk("p3_count", q.size(), 5);
    check_frame("p3", 0, e_p3);

    q.delete();
    send_frame(x_2, y_1, 0);
    tick(4);
    chk("21_count", q.size(), 5);
    check_frame("21", 0, e_21);

    q.delete();
    send_frame(x_m3, x_m3, 0);
    tick(4);
    chk("m3_count", q.size(), 5);
    check_frame("m3", 0, e_m3);

    // back-to-back frames with in_valid held high
    q.delete();
    rdy_low = 0;
    cnt_rdy = 1'b1;
    send_frame(x_p3, x_p3, 0);
    send_frame(x_m3, x_m3, 0);
    tick(4);
    cnt_rdy = 1'b0;
    chk("b2b_ready_low", rdy_low, 2);
    chk("b2b_count", q.size(), 10);
    check_frame("b2b0", 0, e_p3);
    check_frame("b2b1", 5, e_m3);

    // gaps mid-frame and a stray non-first pair in IDLE
    q.delete();
    send(3'b011, 3'b011, 1'b0);
    tick(2);
    chk("drop_count", q.size(), 0);
    send_frame(x_2, y_1, 2);
    tick(4);
    chk("gap_count", q.size(), 5);
    check_frame("gap", 0, e_21);

    // reset mid-frame
    q.delete();
    send(3'b011, 3'b011, 1'b1);
    send(3'b011, 3'b011, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_last", int'(out_last), 0);
    chk("mid_rst_digit", int'(out_digit), 0);
    chk("mid_rst_ready", int'(in_ready), 1);
    tick(1);
    reset = 1'b0;
    tick(2);
    nlast = 0;
    foreach (q[i]) if (q[i].l) nlast++;
    chk("mid_rst_nolast", nlast, 0);
    q.delete();
    send_frame(x_p3, x_p3, 0);
    tick(4);
    chk("post_rst_count", q.size(), 5);
    check_frame("post_rst", 0, e_p3);

    // illegal digit -r
    send_frame(x_bad, zero4, 0);
    tick(1);
`ifdef HRADD_DIGIT_CHECK_EN
    chk("err_set", int'(err), 1);
    tick(5);
    chk("err_sticky", int'(err), 1);
`else
    chk("err_off", int'(err), 0);
    tick(5);
    chk("err_off_late", int'(err), 0);
`endif
    reset = 1'b1;
    tick(1);
    chk("err_cleared", int'(err), 0);
    reset = 1'b0;
    tick(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout got %0d exp %0d", 1, 0);
    $fatal(1);
  end

endmodule
